// File: rtl/dec_rr_arbiter8.sv
// dec_rr_arbiter8
// Round-robin arbiter sharing one 3-to-8 decoder among eight requesters.
// A single grantee at a time drives the decoder select code and enable.
// Grants are bounded to HOLD_MAX cycles while others wait, and every
// handover passes through a one-cycle dead gap so that two decoder outputs
// are never active in the same cycle.
//
// Ports:
//   clk   in   1  system clock, rising edge
//   rstn  in   1  asynchronous active-low reset
//   req   in   8  request vector, bit i = requester i
//   sel   out  3  binary id of current grantee (holds its value in GAP/IDLE)
//   en    out  1  decoder enable, high only while granting
//   gnt   out  8  one-hot grant, decode of sel when en=1, else 8'h00
//   busy  out  1  high while granting or in the dead gap
module dec_rr_arbiter8 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic       en,
  output logic [7:0] gnt,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_C = 4'(HOLD_MAX);

  state_t     state_r;
  logic [2:0] sel_r;
  logic       en_r;
  logic [7:0] gnt_r;
  logic       busy_r;
  logic [3:0] hold_r;
  logic [2:0] last_r;

  logic [3:0] pick_s;     // {found, id}
  logic       others_s;   // some requester other than the grantee is waiting
  logic       release_s;  // grantee dropped its request
  logic       preempt_s;  // hold budget used up with others waiting

  // Search req starting one above the last grantee, wrapping 7 -> 0.
  // Iterating from the farthest offset down lets the nearest hit win.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int k = 8; k >= 1; k--) begin
      idx = last + 3'(k);
      res = r[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] id);
    return 8'b0000_0001 << id;
  endfunction

  // Combinational arbitration and handover conditions.
  always_comb begin
    pick_s    = rr_pick(req, last_r);
    others_s  = |(req & ~onehot8(sel_r));
    release_s = ~req[sel_r];
    preempt_s = (hold_r == HOLD_C) & others_s;
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      sel_r   <= 3'd0;
      en_r    <= 1'b0;
      gnt_r   <= 8'h00;
      busy_r  <= 1'b0;
      hold_r  <= 4'd0;
      last_r  <= 3'd7;
    end else begin
      case (state_r)
        IDLE, GAP: begin
          if (pick_s[3]) begin
            state_r <= GRANT;
            sel_r   <= pick_s[2:0];
            en_r    <= 1'b1;
            gnt_r   <= onehot8(pick_s[2:0]);
            busy_r  <= 1'b1;
            hold_r  <= 4'd1;
            last_r  <= pick_s[2:0];
          end else begin
            state_r <= IDLE;
            en_r    <= 1'b0;
            gnt_r   <= 8'h00;
            busy_r  <= 1'b0;
          end
        end
        GRANT: begin
          // A release on the same edge the budget expires lands in GAP too.
          if (release_s || preempt_s) begin
            state_r <= GAP;
            en_r    <= 1'b0;
            gnt_r   <= 8'h00;
            busy_r  <= 1'b1;
          end else begin
            state_r <= GRANT;
            hold_r  <= (hold_r == HOLD_C) ? hold_r : hold_r + 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          en_r    <= 1'b0;
          gnt_r   <= 8'h00;
          busy_r  <= 1'b0;
          hold_r  <= 4'd0;
        end
      endcase
    end
  end

  assign sel  = sel_r;
  assign en   = en_r;
  assign gnt  = gnt_r;
  assign busy = busy_r;

endmodule
